// File: rtl/cache_pkg.sv
// Shared constants, FSM state encoding and address-field helpers for the
// direct-mapped cache refill controller.
package cache_pkg;

  localparam int ADDR_W         = 32;
  localparam int NUM_LINES      = 256;
  localparam int WORDS_PER_LINE = 16;
  localparam int IDX_W          = $clog2(NUM_LINES);
  localparam int WORD_W         = $clog2(WORDS_PER_LINE);
  localparam int BYTE_OFF       = 2;
  localparam int TAG_W          = ADDR_W - IDX_W - WORD_W - BYTE_OFF;
  localparam int LINE_OFF       = WORD_W + BYTE_OFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_REFILL,
    ST_RESP,
    ST_FLUSH
  } state_t;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return a[LINE_OFF +: IDX_W];
  endfunction

  function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
    return a[BYTE_OFF +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// CPU load path, data-array and memory-bus signals of the refill controller.
// master = controller side, slave = CPU / RAM / memory side.
interface cache_refill_ctrl_if;
  import cache_pkg::*;

  logic                cpu_req_valid;
  logic                cpu_req_ready;
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_resp_valid;
  logic                cpu_resp_ready;
  logic [31:0]         cpu_resp_data;
  logic                cpu_resp_hit;

  logic                da_rd_en;
  logic                da_wr_en;
  logic [IDX_W-1:0]    da_index;
  logic [WORD_W-1:0]   da_word;
  logic [31:0]         da_wr_data;
  logic [31:0]         da_rd_data;

  logic                mem_req;
  logic [ADDR_W-1:0]   mem_addr;
  logic                mem_ack;
  logic [31:0]         mem_rdata;

  modport master (
    input  cpu_req_valid, cpu_addr, cpu_resp_ready, da_rd_data, mem_ack, mem_rdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
           da_rd_en, da_wr_en, da_index, da_word, da_wr_data, mem_req, mem_addr
  );

  modport slave (
    output cpu_req_valid, cpu_addr, cpu_resp_ready, da_rd_data, mem_ack, mem_rdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_hit,
           da_rd_en, da_wr_en, da_index, da_word, da_wr_data, mem_req, mem_addr
  );

endinterface

// File: rtl/cache_tag_store.sv
// Tag flops plus valid bits for every line; one write port, combinational
// hit compare, and a one-cycle bulk invalidate that leaves tags untouched.
module cache_tag_store
  import cache_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inv_all,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [IDX_W-1:0] lk_idx,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             lk_hit
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tags [NUM_LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid         <= '0;
    else if (inv_all) valid         <= '0;
    else if (wr_en)   valid[wr_idx] <= 1'b1;
  end

  // Tags need no reset: a line is only ever trusted through its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) tags[wr_idx] <= wr_tag;
  end

  assign lk_hit = valid[lk_idx] && (tags[lk_idx] == lk_tag);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Single-outstanding read controller: tag lookup against the external data
// array, full-line refill from memory on a miss, then a held CPU response.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  cache_refill_ctrl_if.master  bus,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]   beat;
  logic [31:0]         resp_data;
  logic                resp_hit;
  logic                accept, ack, last_ack, lk_hit;

  assign accept   = bus.cpu_req_valid && bus.cpu_req_ready;
  assign ack      = (state == ST_REFILL) && bus.mem_ack;
  assign last_ack = ack && (beat == WORD_W'(WORDS_PER_LINE - 1));

  cache_tag_store u_tags (
    .clk     (clk),
    .rst_n   (rst_n),
    .inv_all (state == ST_FLUSH),
    .wr_en   (last_ack),
    .wr_idx  (addr_idx(addr_q)),
    .wr_tag  (addr_tag(addr_q)),
    .lk_idx  (addr_idx(addr_q)),
    .lk_tag  (addr_tag(addr_q)),
    .lk_hit  (lk_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (flush) nxt = ST_FLUSH;
                 else if (accept) nxt = ST_LOOKUP;
      ST_LOOKUP: nxt = lk_hit ? ST_RESP : ST_REFILL;
      ST_REFILL: if (last_ack) nxt = ST_RESP;
      ST_RESP:   if (bus.cpu_resp_ready) nxt = ST_IDLE;
      ST_FLUSH:  nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_req_ready  = rst_n && (state == ST_IDLE) && !flush;
    bus.cpu_resp_valid = (state == ST_RESP);
    bus.da_rd_en       = 1'b0;
    bus.da_wr_en       = 1'b0;
    bus.da_index       = '0;
    bus.da_word        = '0;
    bus.da_wr_data     = '0;
    bus.mem_req        = 1'b0;
    bus.mem_addr       = '0;
    case (state)
      ST_IDLE: if (accept) begin
        bus.da_rd_en = 1'b1;
        bus.da_index = addr_idx(bus.cpu_addr);
        bus.da_word  = addr_word(bus.cpu_addr);
      end
      ST_REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {addr_q[ADDR_W-1:LINE_OFF], beat, 2'b00};
        if (bus.mem_ack) begin
          bus.da_wr_en   = 1'b1;
          bus.da_index   = addr_idx(addr_q);
          bus.da_word    = beat;
          bus.da_wr_data = bus.mem_rdata;
        end
      end
      default: ;
    endcase
  end

  assign bus.cpu_resp_data = resp_data;
  assign bus.cpu_resp_hit  = resp_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      beat       <= '0;
      resp_data  <= '0;
      resp_hit   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept) addr_q <= bus.cpu_addr;
      if (state == ST_LOOKUP) begin
        if (lk_hit) begin
          resp_data <= bus.da_rd_data;
          resp_hit  <= 1'b1;
          hit_count <= hit_count + 32'd1;
        end else begin
          resp_hit   <= 1'b0;
          beat       <= '0;
          miss_count <= miss_count + 32'd1;
        end
      end
      // The requested word is forwarded as it streams past; the rest only go to the array.
      if (ack) begin
        if (beat == addr_word(addr_q)) resp_data <= bus.mem_rdata;
        beat <= beat + 1'b1;
      end
    end
  end

endmodule
